// File: rtl/dual_prio_pkg.sv
// Shared sizing, FSM state encoding and index-to-grant mapping for the
// dual priority grant decoder.
package dual_prio_pkg;

  localparam int N_REQ = 12;
  localparam int IDX_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_G1   = 2'd1,
    ST_G2   = 2'd2
  } state_t;

  // Index 0 is the MSB grant line; out-of-range indices map to an all-zero vector.
  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (idx == IDX_W'(i)) v[N_REQ-1-i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/prio_index_decoder.sv
// Combinational priority-index decoder: one-hot grant vector plus range flag.
module prio_index_decoder
  import dual_prio_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output logic [N_REQ-1:0] onehot,
  output logic             in_range
);

  assign onehot   = idx_to_onehot(idx);
  assign in_range = ({1'b0, idx} < (IDX_W+1)'(N_REQ));

endmodule

// File: rtl/dual_priority_grant_decoder.sv
// Accepts one {first, second} priority-index pair and replays it as up to two
// registered one-hot grants, each held until the consumer accepts it.
module dual_priority_grant_decoder
  import dual_prio_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] y1,
  input  logic             y1_vld,
  input  logic [IDX_W-1:0] y2,
  input  logic             y2_vld,
  output logic [N_REQ-1:0] grant,
  output logic             grant_valid,
  input  logic             grant_ready,
  output logic             grant_last,
  output logic             err
);

  state_t           state, state_nx;
  logic [N_REQ-1:0] grant_nx;
  logic             grant_valid_nx, grant_last_nx, err_nx;
  logic [N_REQ-1:0] y2_grant, y2_grant_nx;
  logic             y2_kept, y2_kept_nx;

  logic [N_REQ-1:0] y1_onehot, y2_onehot;
  logic             y1_in_range, y2_in_range;
  logic             accept, y1_keep, y2_keep, malformed;

  prio_index_decoder u_dec_y1 (.idx(y1), .onehot(y1_onehot), .in_range(y1_in_range));
  prio_index_decoder u_dec_y2 (.idx(y2), .onehot(y2_onehot), .in_range(y2_in_range));

  assign in_ready = (state == ST_IDLE) && !rst;
  assign accept   = in_valid && in_ready;

  assign y1_keep   = y1_vld && y1_in_range;
  assign y2_keep   = y1_keep && y2_vld && y2_in_range && (y2 > y1);
  assign malformed = (y1_vld && !y1_in_range) ||
                     (y2_vld && !y1_vld) ||
                     (y2_vld && !y2_in_range) ||
                     (y1_vld && y2_vld && (y2 <= y1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_last  <= 1'b0;
      err         <= 1'b0;
      y2_grant    <= '0;
      y2_kept     <= 1'b0;
    end else begin
      state       <= state_nx;
      grant       <= grant_nx;
      grant_valid <= grant_valid_nx;
      grant_last  <= grant_last_nx;
      err         <= err_nx;
      y2_grant    <= y2_grant_nx;
      y2_kept     <= y2_kept_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    grant_nx       = grant;
    grant_valid_nx = grant_valid;
    grant_last_nx  = grant_last;
    err_nx         = 1'b0;
    y2_grant_nx    = y2_grant;
    y2_kept_nx     = y2_kept;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          err_nx      = malformed;
          y2_grant_nx = y2_onehot;
          y2_kept_nx  = y2_keep;
          // A pair without a usable first index is consumed without granting.
          if (y1_keep) begin
            state_nx       = ST_G1;
            grant_nx       = y1_onehot;
            grant_valid_nx = 1'b1;
            grant_last_nx  = !y2_keep;
          end
        end
      end
      ST_G1: begin
        if (grant_ready) begin
          if (y2_kept) begin
            state_nx      = ST_G2;
            grant_nx      = y2_grant;
            grant_last_nx = 1'b1;
          end else begin
            state_nx       = ST_IDLE;
            grant_nx       = '0;
            grant_valid_nx = 1'b0;
            grant_last_nx  = 1'b0;
          end
          y2_kept_nx = 1'b0;
        end
      end
      ST_G2: begin
        if (grant_ready) begin
          state_nx       = ST_IDLE;
          grant_nx       = '0;
          grant_valid_nx = 1'b0;
          grant_last_nx  = 1'b0;
        end
      end
      default: begin
        state_nx       = ST_IDLE;
        grant_nx       = '0;
        grant_valid_nx = 1'b0;
        grant_last_nx  = 1'b0;
        y2_kept_nx     = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_dual_priority_grant_decoder.sv
// Scoreboard bench: accepted pairs push expected grants/err pulses; a monitor
// compares them against the DUT outputs every falling edge.
module tb_dual_priority_grant_decoder;

  localparam int NR = 12;

  typedef struct {
    logic [NR-1:0] g;
    logic          last;
  } exp_t;

  typedef struct {
    int   cyc;
    logic val;
  } err_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    y1 = '0, y2 = '0;
  logic          y1_vld = 1'b0, y2_vld = 1'b0;
  logic [NR-1:0] grant;
  logic          grant_valid;
  logic          grant_ready = 1'b0;
  logic          grant_last;
  logic          err;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  bit   gr_mode = 1'b1;
  logic gr_force = 1'b0;

  exp_t exp_q[$];
  err_t err_q[$];

  dual_priority_grant_decoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .y1(y1), .y1_vld(y1_vld), .y2(y2), .y2_vld(y2_vld),
    .grant(grant), .grant_valid(grant_valid), .grant_ready(grant_ready),
    .grant_last(grant_last), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    grant_ready = gr_mode ? gr_force : ($urandom_range(0, 3) != 0);
  end

  // Reference: the grant list and error flag a pair should produce.
  function automatic void model(input int a, input bit av, input int b, input bit bv,
                                output exp_t gl[$], output bit e);
    bit k1, k2;
    exp_t x;
    k1 = av && (a < NR);
    k2 = k1 && bv && (b < NR) && (b > a);
    e  = (av && a >= NR) || (bv && !av) || (bv && b >= NR) || (av && bv && b <= a);
    gl = {};
    if (k1) begin
      x.g = '0; x.g[NR-1-a] = 1'b1; x.last = !k2; gl.push_back(x);
    end
    if (k2) begin
      x.g = '0; x.g[NR-1-b] = 1'b1; x.last = 1'b1; gl.push_back(x);
    end
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [3:0] a, input logic av, input logic [3:0] b, input logic bv);
    int   t;
    exp_t gl[$];
    bit   e;
    err_t er;
    y1 = a; y1_vld = av; y2 = b; y2_vld = bv; in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 100) begin @(negedge clk); t++; end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, t);
      in_valid = 1'b0;
      return;
    end
    model(int'(a), av, int'(b), bv, gl, e);
    foreach (gl[i]) exp_q.push_back(gl[i]);
    er.cyc = cyc + 1; er.val = e;
    err_q.push_back(er);
    @(posedge clk); #1;
    in_valid = 1'b0;
    y1 = 4'($urandom); y2 = 4'($urandom); y1_vld = 1'($urandom); y2_vld = 1'($urandom);
    if (gl.size() == 0) begin
      tests++;
      if (in_ready !== 1'b1) begin
        fails++;
        $display("FAIL ready_after_nogrant: in_ready=%0b, required 1", in_ready);
      end
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    logic e_exp;
    if (!rst) begin
      e_exp = 1'b0;
      if (err_q.size() > 0 && err_q[0].cyc == cyc) e_exp = err_q.pop_front().val;
      tests++;
      if (err !== e_exp) begin
        fails++;
        $display("FAIL err_pulse: cyc=%0d err=%0b, required %0b", cyc, err, e_exp);
      end
      tests++;
      if (in_ready !== !grant_valid) begin
        fails++;
        $display("FAIL ready_vs_busy: in_ready=%0b grant_valid=%0b, required in_ready=%0b",
                 in_ready, grant_valid, !grant_valid);
      end
      if (grant_valid) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_grant: grant=%b last=%0b, required no grant", grant, grant_last);
        end else if (grant !== exp_q[0].g || grant_last !== exp_q[0].last) begin
          fails++;
          $display("FAIL grant_value: grant=%b last=%0b, required grant=%b last=%0b",
                   grant, grant_last, exp_q[0].g, exp_q[0].last);
        end
        if (grant_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      end else begin
        tests++;
        if (grant !== '0 || grant_last !== 1'b0) begin
          fails++;
          $display("FAIL idle_outputs: grant=%b last=%0b, required 0 and 0", grant, grant_last);
        end
      end
    end
  end

  initial begin
    int t;
    // Reset state
    #2;
    tests++;
    if (grant !== '0 || grant_valid !== 1'b0 || grant_last !== 1'b0 || err !== 1'b0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: grant=%b gv=%0b last=%0b err=%0b rdy=%0b, required all 0",
               grant, grant_valid, grant_last, err, in_ready);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL ready_after_reset: in_ready=%0b, required 1", in_ready);
    end
    @(posedge clk); #1;

    // Two grants, consumer always ready
    gr_force = 1'b1;
    send(4'd1, 1'b1, 4'd2, 1'b1);
    repeat (3) @(posedge clk); #1;

    // Single grant held while consumer stalls
    gr_force = 1'b0;
    send(4'd0, 1'b1, 4'd7, 1'b0);
    repeat (5) @(posedge clk); #1;
    gr_force = 1'b1;
    repeat (3) @(posedge clk); #1;

    // Descending pair: err, y2 dropped
    send(4'd3, 1'b1, 4'd1, 1'b1);
    repeat (3) @(posedge clk); #1;

    // Out-of-range first index, empty pair, back-to-back empty pair
    send(4'd12, 1'b1, 4'd0, 1'b0);
    send(4'd0, 1'b0, 4'd0, 1'b0);
    send(4'd5, 1'b0, 4'd9, 1'b0);
    send(4'd11, 1'b1, 4'd15, 1'b1);
    repeat (3) @(posedge clk); #1;
    send(4'd10, 1'b1, 4'd11, 1'b1);
    repeat (4) @(posedge clk); #1;

    // Reset mid-transaction with y2 pending
    gr_force = 1'b0;
    send(4'd2, 1'b1, 4'd5, 1'b1);
    repeat (2) @(posedge clk); #1;
    rst = 1'b1;
    #1;
    tests++;
    if (grant !== '0 || grant_valid !== 1'b0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_txn: grant=%b gv=%0b rdy=%0b, required 0 0 0", grant, grant_valid, in_ready);
    end
    exp_q.delete();
    err_q.delete();
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    gr_force = 1'b1;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL ready_after_midreset: in_ready=%0b, required 1", in_ready);
    end
    repeat (6) @(posedge clk); #1;

    // Randomized traffic with random backpressure
    gr_mode = 1'b0;
    for (int n = 0; n < 400; n++) begin
      logic [3:0] a, b;
      a = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 11));
      b = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 11));
      send(a, ($urandom_range(0, 7) != 0), b, ($urandom_range(0, 3) != 0));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end

    t = 0;
    while (exp_q.size() > 0 && t < 200) begin @(posedge clk); t++; end
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0 || err_q.size() != 0) begin
      fails++;
      $display("FAIL drain: pending grants=%0d pending err=%0d, required 0 and 0",
               exp_q.size(), err_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
